// File: rtl/keypad_timer_ctrl_if.sv
// Keypad timer bus: raw board inputs in, BCD time and status out.
interface keypad_timer_ctrl_if;
  logic [9:0]  key;
  logic        clr;
  logic        entry;
  logic        start;
  logic        pause;
  logic        mode;
  logic [23:0] time_bcd;
  logic [2:0]  digit_cnt;
  logic [2:0]  state;
  logic        tick;
  logic        done;
  logic        alarm;

  modport master (
    output key, clr, entry, start, pause, mode,
    input  time_bcd, digit_cnt, state, tick, done, alarm
  );

  modport slave (
    input  key, clr, entry, start, pause, mode,
    output time_bcd, digit_cnt, state, tick, done, alarm
  );
endinterface

// File: rtl/keypad_timer_ctrl.sv
// HH:MM:SS keypad-entered timer: count-down alarm or count-up stopwatch with
// pause/resume, clear, debounced digit entry and a timed alarm output.
module keypad_timer_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned KEY_SCAN   = 1_000_000,
  parameter int unsigned ALARM_SECS = 10
) (
  input logic                clk,
  input logic                reset,
  keypad_timer_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam int unsigned SW = $clog2(KEY_SCAN);
  localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SCAN_MAX   = SW'(KEY_SCAN - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'((ALARM_SECS == 0) ? 0 : ALARM_SECS - 1);

  state_t        r_state, w_state_nxt;
  logic [9:0]    r_key_s1, r_key_s2, r_key_prev;
  logic [4:0]    r_btn_s1, r_btn_s2;   // {mode, pause, start, entry, clr}
  logic [2:0]    r_edge_q;             // {pause, start, clr} delayed
  logic [SW-1:0] r_scan;
  logic [PW-1:0] r_presc;
  logic [AW-1:0] r_alarm_cnt;
  logic [23:0]   r_preset, r_cnt;
  logic [2:0]    r_digit_cnt;
  logic          r_mode, r_tick, r_done, r_alarm;

  logic          w_clr_rise, w_start_rise, w_pause_rise, w_entry, w_mode;
  logic          w_scan_hit, w_key_new, w_digit_ok, w_presc_wrap;
  logic [3:0]    w_digit;
  logic [23:0]   w_cnt_step, w_target;
  logic          w_load, w_load_idle, w_expire, w_enter;

  function automatic logic [23:0] f_bcd_dec(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       b;
    {h1, h0, m1, m0, s1, s0} = t;
    b  = (s0 == 4'd0); s0 = b ? 4'd9 : s0 - 4'd1;
    if (b) begin b = (s1 == 4'd0); s1 = b ? 4'd5 : s1 - 4'd1; end
    if (b) begin b = (m0 == 4'd0); m0 = b ? 4'd9 : m0 - 4'd1; end
    if (b) begin b = (m1 == 4'd0); m1 = b ? 4'd5 : m1 - 4'd1; end
    if (b) begin b = (h0 == 4'd0); h0 = b ? 4'd9 : h0 - 4'd1; end
    if (b) h1 = (h1 == 4'd0) ? 4'd9 : h1 - 4'd1;
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  function automatic logic [23:0] f_bcd_inc(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic       c;
    {h1, h0, m1, m0, s1, s0} = t;
    c  = (s0 == 4'd9); s0 = c ? 4'd0 : s0 + 4'd1;
    if (c) begin c = (s1 == 4'd5); s1 = c ? 4'd0 : s1 + 4'd1; end
    if (c) begin c = (m0 == 4'd9); m0 = c ? 4'd0 : m0 + 4'd1; end
    if (c) begin c = (m1 == 4'd5); m1 = c ? 4'd0 : m1 + 4'd1; end
    if (c) begin c = (h0 == 4'd9); h0 = c ? 4'd0 : h0 + 4'd1; end
    if (c) h1 = (h1 == 4'd9) ? 4'd0 : h1 + 4'd1;
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  assign w_clr_rise   = r_btn_s2[0] & ~r_edge_q[0];
  assign w_entry      = r_btn_s2[1];
  assign w_start_rise = r_btn_s2[2] & ~r_edge_q[1];
  assign w_pause_rise = r_btn_s2[3] & ~r_edge_q[2];
  assign w_mode       = r_btn_s2[4];

  assign w_scan_hit   = (r_scan == SCAN_MAX);
  assign w_key_new    = w_scan_hit && $onehot(r_key_s2) && (r_key_prev == '0);
  assign w_digit_ok   = w_key_new && (r_digit_cnt < 3'd6) &&
                        !(((r_digit_cnt == 3'd2) || (r_digit_cnt == 3'd4)) && (w_digit > 4'd5));
  assign w_presc_wrap = (r_presc == PRESC_MAX);
  assign w_cnt_step   = r_mode ? f_bcd_inc(r_cnt) : f_bcd_dec(r_cnt);
  assign w_target     = r_mode ? r_preset : '0;

  always_comb begin
    w_digit = '0;
    for (int unsigned i = 0; i < 10; i++)
      if (r_key_s2[i]) w_digit = 4'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_s1   <= '0;
      r_key_s2   <= '0;
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_edge_q   <= '0;
      r_scan     <= '0;
      r_key_prev <= '0;
    end else begin
      r_key_s1   <= bus.key;
      r_key_s2   <= r_key_s1;
      r_btn_s1   <= {bus.mode, bus.pause, bus.start, bus.entry, bus.clr};
      r_btn_s2   <= r_btn_s1;
      r_edge_q   <= {r_btn_s2[3], r_btn_s2[2], r_btn_s2[0]};
      r_scan     <= w_scan_hit ? '0 : r_scan + SW'(1);
      if (w_scan_hit) r_key_prev <= r_key_s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Expiry is judged on the stepped count so DONE lands on the same tick;
  // the unstepped compare covers a zero preset, which never ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idle = 1'b0;
    w_expire    = 1'b0;
    w_enter     = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_entry) begin
          w_state_nxt = S_ENTRY;
          w_enter     = 1'b1;
        end else if (w_start_rise) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
          w_load_idle = 1'b1;
        end
      S_ENTRY:
        if (!w_entry) w_state_nxt = S_IDLE;
      S_RUN:
        if ((r_cnt == w_target) || (w_presc_wrap && (w_cnt_step == w_target))) begin
          w_state_nxt = S_DONE;
          w_expire    = 1'b1;
        end else if (w_pause_rise) begin
          w_state_nxt = S_PAUSE;
        end
      S_PAUSE:
        if (w_start_rise) w_state_nxt = S_RUN;
      S_DONE:
        if (w_start_rise) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_clr_rise) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
      w_load_idle = 1'b0;
      w_expire    = 1'b0;
      w_enter     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_preset    <= '0;
      r_cnt       <= '0;
      r_digit_cnt <= '0;
      r_presc     <= '0;
      r_mode      <= 1'b0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else if (w_clr_rise) begin
      r_preset    <= '0;
      r_cnt       <= '0;
      r_digit_cnt <= '0;
      r_presc     <= '0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_tick <= (r_state == S_RUN) && w_presc_wrap;
      r_done <= w_expire;
      if (w_enter) begin
        r_preset    <= '0;
        r_digit_cnt <= '0;
      end else if ((r_state == S_ENTRY) && w_digit_ok) begin
        case (r_digit_cnt)
          3'd0:    r_preset[23:20] <= w_digit;
          3'd1:    r_preset[19:16] <= w_digit;
          3'd2:    r_preset[15:12] <= w_digit;
          3'd3:    r_preset[11:8]  <= w_digit;
          3'd4:    r_preset[7:4]   <= w_digit;
          default: r_preset[3:0]   <= w_digit;
        endcase
        r_digit_cnt <= r_digit_cnt + 3'd1;
      end
      if (w_load_idle) r_mode <= w_mode;
      if (w_load) begin
        r_cnt   <= (w_load_idle ? w_mode : r_mode) ? '0 : r_preset;
        r_presc <= '0;
      end else begin
        if ((r_state == S_RUN) || (r_state == S_DONE))
          r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
        else if ((r_state == S_IDLE) || (r_state == S_ENTRY))
          r_presc <= '0;
        if ((r_state == S_RUN) && w_presc_wrap) r_cnt <= w_cnt_step;
      end
      if (w_expire) begin
        r_alarm     <= 1'b1;
        r_alarm_cnt <= '0;
      end else if (r_state == S_DONE) begin
        if (w_load) begin
          r_alarm <= 1'b0;
        end else if (w_presc_wrap && r_alarm && (ALARM_SECS != 0)) begin
          if (r_alarm_cnt == ALARM_LAST) r_alarm <= 1'b0;
          else                           r_alarm_cnt <= r_alarm_cnt + AW'(1);
        end
      end
    end
  end

  assign bus.time_bcd  = ((r_state == S_IDLE) || (r_state == S_ENTRY)) ? r_preset : r_cnt;
  assign bus.digit_cnt = r_digit_cnt;
  assign bus.state     = r_state;
  assign bus.tick      = r_tick;
  assign bus.done      = r_done;
  assign bus.alarm     = r_alarm;
endmodule

// File: tb/tb_keypad_timer_ctrl.sv
// Bench for keypad_timer_ctrl: directed and random presets checked against a
// seconds-based reference model of entry, counting, pause and alarm rules.
module tb_keypad_timer_ctrl;
  localparam int unsigned CLK_HZ     = 10;
  localparam int unsigned KEY_SCAN   = 4;
  localparam int unsigned ALARM_SECS = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  keypad_timer_ctrl_if u_if ();

  keypad_timer_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .KEY_SCAN  (KEY_SCAN),
    .ALARM_SECS(ALARM_SECS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pd[6];
  int pos;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] secs_bcd(input int s);
    int h, m, x;
    h = (s / 3600) % 100;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [23:0] preset_bcd();
    return {4'(pd[0]), 4'(pd[1]), 4'(pd[2]), 4'(pd[3]), 4'(pd[4]), 4'(pd[5])};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_digit(input int d);
    if (pos < 6 && !((pos == 2 || pos == 4) && d > 5)) begin
      pd[pos] = d;
      pos++;
    end
  endtask

  task automatic press_key(input int d, input int hold);
    model_digit(d);
    u_if.key = 10'(1 << d);
    cycles(hold);
    u_if.key = '0;
    cycles(16);
  endtask

  task automatic begin_entry();
    u_if.entry = 1'b1;
    cycles(4);
    pd  = '{default: 0};
    pos = 0;
  endtask

  task automatic end_entry();
    u_if.entry = 1'b0;
    cycles(4);
  endtask

  task automatic enter6(input int a, input int b, input int c, input int d, input int e, input int f);
    begin_entry();
    press_key(a, 12); press_key(b, 12); press_key(c, 12);
    press_key(d, 12); press_key(e, 12); press_key(f, 12);
    end_entry();
  endtask

  task automatic pulse_clr();
    u_if.clr = 1'b1; cycles(4); u_if.clr = 1'b0; cycles(2);
    pd  = '{default: 0};
    pos = 0;
  endtask

  task automatic pulse_start();
    u_if.start = 1'b1; cycles(4); u_if.start = 1'b0; cycles(2);
  endtask

  task automatic wait_tick(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 3 * CLK_HZ; i++) begin
      @(negedge clk);
      cyc++;
      if (u_if.tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_to_done(input bit up, input int ps);
    int v, cyc, a;
    bit seen;
    v = up ? 0 : ps;
    for (int k = 0; k < ps + 1; k++) begin
      wait_tick(cyc, seen);
      check("tick_seen", seen, 1);
      if (!seen) return;
      if (k > 0) check("tick_period", cyc, CLK_HZ);
      v = up ? v + 1 : v - 1;
      check("count", u_if.time_bcd, secs_bcd(v));
      if (v == (up ? ps : 0)) break;
      check("done_early", u_if.done, 0);
    end
    check("done_pulse", u_if.done, 1);
    check("done_state", u_if.state, 4);
    check("alarm_rise", u_if.alarm, 1);
    a = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) check("done_width", u_if.done, 0);
      if (u_if.alarm !== 1'b1) break;
      a++;
    end
    check("alarm_cycles", a, ALARM_SECS * CLK_HZ);
    check("done_hold", u_if.state, 4);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ps, v, nt, nd;
    bit seen, up;
    u_if.key = '0; u_if.clr = 1'b0; u_if.entry = 1'b0;
    u_if.start = 1'b0; u_if.pause = 1'b0; u_if.mode = 1'b0;
    pd = '{default: 0};
    pos = 0;
    cycles(3);
    check("rst_time", u_if.time_bcd, 0);
    check("rst_dcnt", u_if.digit_cnt, 0);
    check("rst_state", u_if.state, 0);
    check("rst_tick", u_if.tick, 0);
    check("rst_done", u_if.done, 0);
    check("rst_alarm", u_if.alarm, 0);
    reset = 1'b1;
    cycles(3);
    check("idle_state", u_if.state, 0);

    // digit validation: 7 in M1 rejected, then 3 accepted
    begin_entry();
    check("entry_state", u_if.state, 1);
    press_key(1, 12); press_key(2, 12); press_key(7, 12);
    check("reject_dcnt", u_if.digit_cnt, pos);
    check("reject_dcnt_abs", u_if.digit_cnt, 2);
    press_key(3, 12);
    check("preset_123", u_if.time_bcd, 24'h123000);
    check("preset_model", u_if.time_bcd, preset_bcd());
    end_entry();
    check("idle_keep_preset", u_if.time_bcd, 24'h123000);
    check("idle_state2", u_if.state, 0);

    // random digit streams, including over-range and 7th+ digits
    for (int r = 0; r < 2; r++) begin
      begin_entry();
      for (int i = 0; i < 8; i++) begin
        press_key(int'($urandom_range(0, 9)), 12 + int'($urandom_range(0, 8)));
        check("rand_dcnt", u_if.digit_cnt, pos);
        check("rand_preset", u_if.time_bcd, preset_bcd());
      end
      end_entry();
    end

    // multi-key ignored; held single key accepted once
    begin_entry();
    check("entry_clears", u_if.time_bcd, 0);
    u_if.key = 10'b00_0001_1000;
    cycles(16);
    u_if.key = '0;
    cycles(16);
    check("multikey_dcnt", u_if.digit_cnt, 0);
    press_key(5, 60);
    check("held_dcnt", u_if.digit_cnt, 1);
    check("held_preset", u_if.time_bcd, 24'h500000);
    end_entry();
    pulse_clr();
    check("clr_time", u_if.time_bcd, 0);
    check("clr_dcnt", u_if.digit_cnt, 0);
    check("clr_state", u_if.state, 0);

    // 00:01:05 count-down with alarm
    enter6(0, 0, 0, 1, 0, 5);
    check("preset_0105", u_if.time_bcd, secs_bcd(65));
    u_if.mode = 1'b0;
    cycles(2);
    pulse_start();
    check("run_state", u_if.state, 2);
    run_to_done(1'b0, 65);
    pulse_clr();
    check("clr_after_done", u_if.state, 0);
    check("clr_alarm", u_if.alarm, 0);

    // zero preset: DONE one cycle after start is seen, no tick
    u_if.start = 1'b1;
    nt = 0;
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (u_if.tick === 1'b1) nt++;
      if (u_if.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    u_if.start = 1'b0;
    check("zero_done_seen", seen, 1);
    check("zero_latency", cyc, 4);
    check("zero_no_tick", nt, 0);
    check("zero_state", u_if.state, 4);
    pulse_clr();

    // count up to 00:00:02
    enter6(0, 0, 0, 0, 0, 2);
    u_if.mode = 1'b1;
    cycles(2);
    pulse_start();
    run_to_done(1'b1, 2);
    pulse_clr();

    // borrow across hours
    enter6(0, 1, 0, 0, 0, 0);
    u_if.mode = 1'b0;
    cycles(2);
    pulse_start();
    wait_tick(cyc, seen);
    check("borrow_tick", seen, 1);
    check("borrow_val", u_if.time_bcd, secs_bcd(3599));
    pulse_clr();

    // pause at 00:00:40, resume keeps phase; pause on the expiry tick loses to DONE
    enter6(0, 0, 0, 0, 4, 5);
    pulse_start();
    v = 45;
    for (int k = 0; k < 5; k++) begin
      wait_tick(cyc, seen);
      v--;
      check("pre_pause_tick", seen, 1);
      check("pre_pause_val", u_if.time_bcd, secs_bcd(v));
    end
    u_if.pause = 1'b1;
    nt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 3) u_if.pause = 1'b0;
      if (u_if.tick === 1'b1) nt++;
    end
    check("pause_no_tick", nt, 0);
    check("pause_state", u_if.state, 3);
    check("pause_hold", u_if.time_bcd, secs_bcd(40));
    u_if.start = 1'b1;
    wait_tick(cyc, seen);
    u_if.start = 1'b0;
    v--;
    check("resume_tick", seen, 1);
    check("resume_phase", cyc, CLK_HZ);
    check("resume_val", u_if.time_bcd, secs_bcd(v));
    while (v > 1) begin
      wait_tick(cyc, seen);
      check("drain_tick", seen, 1);
      if (!seen) break;
      v--;
      check("drain_val", u_if.time_bcd, secs_bcd(v));
    end
    cycles(7);
    u_if.pause = 1'b1;
    wait_tick(cyc, seen);
    u_if.pause = 1'b0;
    check("expire_pause_tick", seen, 1);
    check("expire_pause_cyc", cyc, 3);
    check("expire_pause_state", u_if.state, 4);
    check("expire_pause_done", u_if.done, 1);
    check("expire_pause_val", u_if.time_bcd, 0);
    pulse_clr();

    // clr mid-run at 00:00:30
    enter6(0, 0, 0, 0, 3, 3);
    pulse_start();
    for (int k = 0; k < 3; k++) wait_tick(cyc, seen);
    check("pre_clr_val", u_if.time_bcd, secs_bcd(30));
    u_if.clr = 1'b1;
    cycles(3);
    check("clr_run_state", u_if.state, 0);
    check("clr_run_time", u_if.time_bcd, 0);
    check("clr_run_alarm", u_if.alarm, 0);
    check("clr_run_tick", u_if.tick, 0);
    u_if.clr = 1'b0;
    cycles(2);
    pd = '{default: 0};
    pos = 0;

    // random presets and modes, then restart from DONE with mode input flipped
    for (int r = 0; r < 3; r++) begin
      ps = int'($urandom_range(1, 119));
      up = 1'($urandom_range(0, 1));
      enter6(0, 0, 0, ps / 60, (ps % 60) / 10, ps % 10);
      check("rand_run_preset", u_if.time_bcd, secs_bcd(ps));
      u_if.mode = up;
      cycles(2);
      pulse_start();
      run_to_done(up, ps);
      u_if.mode = ~up;
      cycles(2);
      pulse_start();
      check("restart_state", u_if.state, 2);
      wait_tick(cyc, seen);
      check("restart_tick", seen, 1);
      check("restart_val", u_if.time_bcd, secs_bcd(up ? 1 : ps - 1));
      pulse_clr();
    end

    // asynchronous reset mid-run
    enter6(0, 0, 0, 0, 0, 9);
    u_if.mode = 1'b0;
    cycles(2);
    pulse_start();
    wait_tick(cyc, seen);
    wait_tick(cyc, seen);
    cycles(3);
    reset = 1'b0;
    #1;
    check("mid_rst_time", u_if.time_bcd, 0);
    check("mid_rst_state", u_if.state, 0);
    check("mid_rst_dcnt", u_if.digit_cnt, 0);
    check("mid_rst_alarm", u_if.alarm, 0);
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (u_if.done === 1'b1) nd++;
    end
    check("mid_rst_no_done", nd, 0);
    reset = 1'b1;
    cycles(4);
    check("post_rst_state", u_if.state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
